// File: rtl/mult_booth_unit_pkg.sv
// Shared constants and state type for the Booth multiplier slice.
package mult_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned STEPS = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_booth_unit_if.sv
// Request/result bundle between a multiply requester and the Booth unit.
interface mult_booth_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic [WIDTH-1:0] product;
  logic             overflow;
  logic             ready;
  logic             busy;

  modport master (
    output start, operandA, operandB,
    input  product, overflow, ready, busy
  );

  modport slave (
    input  start, operandA, operandB,
    output product, overflow, ready, busy
  );

endinterface

// File: rtl/mult_booth_unit_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then
// arithmetic right shift of the whole {A, Q, q_1} register.
module booth_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH+1:0] regIn,
  input  logic [WIDTH:0]     mIn,
  output logic [2*WIDTH+1:0] regOut
);

  logic [WIDTH:0]   accA;
  logic [WIDTH-1:0] accQ;
  logic             qPrev;
  logic [WIDTH:0]   sum;

  assign accA  = regIn[2*WIDTH+1:WIDTH+1];
  assign accQ  = regIn[WIDTH:1];
  assign qPrev = regIn[0];

  // Select add, subtract or hold from the Booth pair {Q[0], q_1}.
  always_comb begin
    sum = accA;
    unique case ({accQ[0], qPrev})
      2'b01:   sum = accA + mIn;
      2'b10:   sum = accA - mIn;
      default: sum = accA;
    endcase
  end

  // Shift right by one: sign of A fills the top, old q_1 falls off the bottom.
  assign regOut = {sum[WIDTH], sum, accQ};

endmodule

// File: rtl/mult_booth_unit.sv
// Sequential signed multiplier, one Booth step per clock, 32 steps per op.
module mult_booth_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
  input logic               clock,
  input logic               resetn,
  mult_booth_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  mult_state_t        state;
  logic [2*WIDTH+1:0] accReg;
  logic [2*WIDTH+1:0] accNext;
  logic [WIDTH:0]     mReg;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   productR;
  logic               overflowR;
  logic [WIDTH-1:0]   upperNext;
  logic [WIDTH-1:0]   lowerNext;

  booth_step #(.WIDTH(WIDTH)) uStep (
    .regIn  (accReg),
    .mIn    (mReg),
    .regOut (accNext)
  );

  assign upperNext = accNext[2*WIDTH:WIDTH+1];
  assign lowerNext = accNext[WIDTH:1];

  // FSM, step counter, operand capture and result registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      accReg    <= '0;
      mReg      <= '0;
      count     <= '0;
      productR  <= '0;
      overflowR <= 1'b0;
    end else if (bus.start) begin
      accReg <= {{(WIDTH+1){1'b0}}, bus.operandB, 1'b0};
      mReg   <= {bus.operandA[WIDTH-1], bus.operandA};
      count  <= '0;
      state  <= RUN;
    end else if (state == RUN) begin
      accReg <= accNext;
      count  <= count + 1'b1;
      if (count == CNT_LAST) begin
        state     <= DONE;
        productR  <= lowerNext;
        overflowR <= (upperNext != {WIDTH{lowerNext[WIDTH-1]}});
      end
    end
  end

  assign bus.product  = productR;
  assign bus.overflow = overflowR;
  assign bus.ready    = (state == DONE);
  assign bus.busy     = (state == RUN);

endmodule

// File: tb/tb_mult_booth_unit.sv
// Directed plus random checks of mult_booth_unit against a 64-bit multiply model.
module tb_mult_booth_unit;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  mult_booth_unit_if #(.WIDTH(32)) bus ();

  mult_booth_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int unsigned nCompared   = 0;
  int unsigned nMismatched = 0;
  logic [31:0] lastProd    = '0;
  logic        lastOvf     = 1'b0;

  function automatic void refMul(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] p, output logic o);
    longint full;
    longint low;
    full = longint'($signed(a)) * longint'($signed(b));
    low  = longint'($signed(full[31:0]));
    p    = full[31:0];
    o    = (full != low);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic startOp(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start    = 1'b1;
    bus.operandA = a;
    bus.operandB = b;
    @(posedge clock);
    #1;
    bus.start    = 1'b0;
    bus.operandA = $urandom;
    bus.operandB = $urandom;
    check("readyDropOnStart", 64'(bus.ready), 64'd0);
    check("busyOnStart", 64'(bus.busy), 64'd1);
  endtask

  task automatic runCheck(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expP;
    logic        expO;
    refMul(a, b, expP, expO);
    repeat (31) @(posedge clock);
    #1;
    check({tag, ".earlyReady"}, 64'(bus.ready), 64'd0);
    check({tag, ".busyStep31"}, 64'(bus.busy), 64'd1);
    check({tag, ".heldProduct"}, 64'(bus.product), 64'(lastProd));
    check({tag, ".heldOverflow"}, 64'(bus.overflow), 64'(lastOvf));
    @(posedge clock);
    #1;
    check({tag, ".ready"}, 64'(bus.ready), 64'd1);
    check({tag, ".busyDone"}, 64'(bus.busy), 64'd0);
    check({tag, ".product"}, 64'(bus.product), 64'(expP));
    check({tag, ".overflow"}, 64'(bus.overflow), 64'(expO));
    lastProd = expP;
    lastOvf  = expO;
  endtask

  task automatic doOp(input string tag, input logic [31:0] a, input logic [31:0] b);
    startOp(a, b);
    runCheck(tag, a, b);
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".ready"}, 64'(bus.ready), 64'd0);
    check({tag, ".busy"}, 64'(bus.busy), 64'd0);
    check({tag, ".product"}, 64'(bus.product), 64'd0);
    check({tag, ".overflow"}, 64'(bus.overflow), 64'd0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.operandA = '0;
    bus.operandB = '0;

    // Reset state
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkResetState("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Directed cases, including the sign and overflow corners
    doOp("pos3x5", 32'd3, 32'd5);
    doOp("neg7x6", 32'hFFFF_FFF9, 32'd6);
    doOp("maxX2", 32'h7FFF_FFFF, 32'd2);
    doOp("minXneg1", 32'h8000_0000, 32'hFFFF_FFFF);
    doOp("minX1", 32'h8000_0000, 32'd1);
    doOp("2xMin", 32'd2, 32'h8000_0000);
    doOp("minXmin", 32'h8000_0000, 32'h8000_0000);
    doOp("zero", 32'd0, 32'h1234_5678);

    // Result and ready hold while idle in DONE
    repeat (3) @(posedge clock);
    #1;
    check("doneHold.ready", 64'(bus.ready), 64'd1);
    check("doneHold.product", 64'(bus.product), 64'(lastProd));

    // Restart mid-run: second start at step 10
    startOp(32'd3, 32'd5);
    repeat (9) @(posedge clock);
    startOp(32'd4, 32'd4);
    runCheck("restart", 32'd4, 32'd4);

    // Random operands, issued back to back from the first DONE cycle
    for (int unsigned i = 0; i < 20; i++) begin
      doOp("random", 32'($urandom), 32'($urandom));
    end

    // Reset at step 20 aborts the operation
    startOp(32'($urandom), 32'($urandom));
    repeat (19) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    checkResetState("resetMidRun");
    lastProd = '0;
    lastOvf  = 1'b0;

    // Reset wins over a simultaneous start
    @(negedge clock);
    bus.start    = 1'b1;
    bus.operandA = 32'd9;
    bus.operandB = 32'd9;
    @(posedge clock);
    #1;
    checkResetState("resetWithStart");
    bus.start = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    checkResetState("idleAfterReset");

    doOp("afterReset", 32'd6, 32'hFFFF_FFF9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
